// File: rtl/shift_pkg.sv
// Shared types and widths for the shift register / deserializer pair.
package shift_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Word width shared with the upstream parallel-load / shift-right register.
    localparam int SHIFT_W = 4;

endpackage

// File: rtl/shift_deserializer_4bit.sv
// Rebuilds LSB-first serial words into DATA_W-bit words; one-entry output buffer.
// Latency: word visible on out_data/out_valid right after the edge sampling its last bit.
// Backpressure: a word completing while the buffer is full and not draining is dropped and flags overrun.
module shift_deserializer_4bit
    import shift_pkg::*;
#(
    parameter int DATA_W = SHIFT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              sin_first,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              clear_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  assembly;

    logic               start_bit;
    logic               data_bit;
    logic               last_bit;
    logic               frame_event;
    logic               can_load;
    logic               overrun_event;
    logic [DATA_W-1:0]  word_next;
    logic [DATA_W-1:0]  word_start;

    assign start_bit     = sin_valid & sin_first;
    assign data_bit      = sin_valid & ~sin_first & (state == COLLECT);
    assign last_bit      = data_bit & (count == CNT_W'(DATA_W - 1));
    assign frame_event   = start_bit & (state == COLLECT);
    assign can_load      = ~out_valid | out_ready;
    assign overrun_event = last_bit & ~can_load;
    assign word_start    = {{(DATA_W-1){1'b0}}, sin};

    // Partial word with the incoming bit dropped into slot [count].
    always_comb begin
        word_next = assembly;
        for (int i = 0; i < DATA_W; i++) begin
            if (count == CNT_W'(i)) begin
                word_next[i] = sin;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            assembly  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_bit) begin
                        assembly <= word_start;
                        count    <= CNT_W'(1);
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (start_bit) begin
                        // Restart: the partial word is abandoned, this bit becomes bit 0.
                        assembly <= word_start;
                        count    <= CNT_W'(1);
                    end else if (last_bit) begin
                        assembly <= '0;
                        count    <= '0;
                        state    <= IDLE;
                    end else if (data_bit) begin
                        assembly <= word_next;
                        count    <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase

            if (last_bit && can_load) begin
                out_data  <= word_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A fresh error event outranks a clear in the same cycle.
            frame_err <= frame_event   | (frame_err & ~clear_err);
            overrun   <= overrun_event | (overrun   & ~clear_err);
        end
    end

endmodule
